// File: rtl/vproc_pkg.sv
// Shared types and defaults for the vector processor hazard-tracking logic.
package vproc_pkg;

    localparam int unsigned HAZARD_ID_W_DEFAULT = 3;

    // One in-flight instruction: outstanding vreg writes and reads.
    typedef struct packed {
        logic        valid;
        logic [31:0] wr;
        logic [31:0] rd;
    } hazard_entry_t;

endpackage

// File: rtl/vproc_lowest_free.sv
// First-zero priority encoder: returns the lowest index whose valid bit is clear.
module vproc_lowest_free #(
    parameter int unsigned N = 8,
    parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] valid,
    output logic [W-1:0] idx,
    output logic         found
);

    // Scan upward; the first clear bit wins and later ones are ignored.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && !valid[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vproc_hazard_tracker.sv
// Tracks vreg write/read hazards of in-flight vector instructions and gates dispatch.
module vproc_hazard_tracker
    import vproc_pkg::*;
#(
    parameter int unsigned ID_W           = HAZARD_ID_W_DEFAULT,
    parameter bit          DONT_CARE_ZERO = 1'b0
) (
    input  logic            clk_i,
    input  logic            sync_rst_i,
    input  logic            disp_valid_i,
    output logic            disp_ready_o,
    output logic [ID_W-1:0] disp_id_o,
    input  logic [31:0]     disp_wr_i,
    input  logic [31:0]     disp_rd_i,
    input  logic            wr_clr_valid_i,
    input  logic [ID_W-1:0] wr_clr_id_i,
    input  logic [31:0]     wr_clr_mask_i,
    input  logic            rd_clr_valid_i,
    input  logic [ID_W-1:0] rd_clr_id_i,
    input  logic [31:0]     rd_clr_mask_i,
    input  logic            done_valid_i,
    input  logic [ID_W-1:0] done_id_i,
    output logic [31:0]     pend_wr_o,
    output logic [31:0]     pend_rd_o,
    output logic            busy_o
);

    localparam int unsigned N = 2 ** ID_W;

    hazard_entry_t   entries      [N];
    hazard_entry_t   entries_next [N];
    logic [N-1:0]    valid_vec;
    logic [ID_W-1:0] alloc_idx;
    logic            alloc_found;
    logic            conflict;
    logic            fire;

    vproc_lowest_free #(
        .N (N),
        .W (ID_W)
    ) u_lowest_free (
        .valid (valid_vec),
        .idx   (alloc_idx),
        .found (alloc_found)
    );

    // Aggregate registered entry state into pending masks and occupancy.
    always_comb begin
        valid_vec = '0;
        pend_wr_o = '0;
        pend_rd_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            valid_vec[i] = entries[i].valid;
            if (entries[i].valid) begin
                pend_wr_o = pend_wr_o | entries[i].wr;
                pend_rd_o = pend_rd_o | entries[i].rd;
            end
        end
        busy_o = |valid_vec;
    end

    // Dispatch handshake: RAW/WAW against pending writes, WAR against pending reads.
    always_comb begin
        conflict     = (|((disp_wr_i | disp_rd_i) & pend_wr_o)) || (|(disp_wr_i & pend_rd_o));
        disp_ready_o = alloc_found && !conflict;
        fire         = disp_valid_i && disp_ready_o;
        if (alloc_found) begin
            disp_id_o = alloc_idx;
        end else begin
            disp_id_o = DONT_CARE_ZERO ? '0 : 'x;
        end
    end

    // Next entry state: allocation into a free slot, partial clears and done on valid slots.
    // Allocation only targets an invalid slot and clears only act on valid ones, so they never collide.
    always_comb begin
        entries_next = entries;
        for (int unsigned i = 0; i < N; i++) begin
            if (entries[i].valid) begin
                if (done_valid_i && done_id_i == ID_W'(i)) begin
                    entries_next[i] = '0;
                end else begin
                    if (wr_clr_valid_i && wr_clr_id_i == ID_W'(i)) begin
                        entries_next[i].wr = entries[i].wr & ~wr_clr_mask_i;
                    end
                    if (rd_clr_valid_i && rd_clr_id_i == ID_W'(i)) begin
                        entries_next[i].rd = entries[i].rd & ~rd_clr_mask_i;
                    end
                end
            end else if (fire && alloc_idx == ID_W'(i)) begin
                entries_next[i] = '{valid: 1'b1, wr: disp_wr_i, rd: disp_rd_i};
            end
        end
    end

    // Entry register with synchronous reset discarding every in-flight instruction.
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            for (int unsigned i = 0; i < N; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                entries[i] <= entries_next[i];
            end
        end
    end

    // Warn about clears/done aimed at slots holding no instruction (ignored by the logic).
    always_ff @(posedge clk_i) begin
        if (!sync_rst_i) begin
            if (wr_clr_valid_i) begin
                assert (entries[wr_clr_id_i].valid)
                    else $warning("wr_clr to invalid id %0d", wr_clr_id_i);
            end
            if (rd_clr_valid_i) begin
                assert (entries[rd_clr_id_i].valid)
                    else $warning("rd_clr to invalid id %0d", rd_clr_id_i);
            end
            if (done_valid_i) begin
                assert (entries[done_id_i].valid)
                    else $warning("done to invalid id %0d", done_id_i);
            end
        end
    end

endmodule

// File: tb/tb_vproc_hazard_tracker.sv
// Directed self-checking bench for vproc_hazard_tracker.
module tb_vproc_hazard_tracker;

    logic        clk_i = 1'b0;
    logic        sync_rst_i;
    logic        disp_valid_i;
    logic        disp_ready_o;
    logic [2:0]  disp_id_o;
    logic [31:0] disp_wr_i;
    logic [31:0] disp_rd_i;
    logic        wr_clr_valid_i;
    logic [2:0]  wr_clr_id_i;
    logic [31:0] wr_clr_mask_i;
    logic        rd_clr_valid_i;
    logic [2:0]  rd_clr_id_i;
    logic [31:0] rd_clr_mask_i;
    logic        done_valid_i;
    logic [2:0]  done_id_i;
    logic [31:0] pend_wr_o;
    logic [31:0] pend_rd_o;
    logic        busy_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    vproc_hazard_tracker #(
        .ID_W           (3),
        .DONT_CARE_ZERO (1'b1)
    ) dut (
        .clk_i          (clk_i),
        .sync_rst_i     (sync_rst_i),
        .disp_valid_i   (disp_valid_i),
        .disp_ready_o   (disp_ready_o),
        .disp_id_o      (disp_id_o),
        .disp_wr_i      (disp_wr_i),
        .disp_rd_i      (disp_rd_i),
        .wr_clr_valid_i (wr_clr_valid_i),
        .wr_clr_id_i    (wr_clr_id_i),
        .wr_clr_mask_i  (wr_clr_mask_i),
        .rd_clr_valid_i (rd_clr_valid_i),
        .rd_clr_id_i    (rd_clr_id_i),
        .rd_clr_mask_i  (rd_clr_mask_i),
        .done_valid_i   (done_valid_i),
        .done_id_i      (done_id_i),
        .pend_wr_o      (pend_wr_o),
        .pend_rd_o      (pend_rd_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        disp_valid_i   = 1'b0;
        disp_wr_i      = '0;
        disp_rd_i      = '0;
        wr_clr_valid_i = 1'b0;
        wr_clr_id_i    = '0;
        wr_clr_mask_i  = '0;
        rd_clr_valid_i = 1'b0;
        rd_clr_id_i    = '0;
        rd_clr_mask_i  = '0;
        done_valid_i   = 1'b0;
        done_id_i      = '0;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        idle();
        sync_rst_i = 1'b1;
        tick();
        sync_rst_i = 1'b0;
    endtask

    task automatic offer(input logic [31:0] wr, input logic [31:0] rd);
        disp_valid_i = 1'b1;
        disp_wr_i    = wr;
        disp_rd_i    = rd;
    endtask

    // Offer and accept one instruction, checking it lands in the expected slot.
    task automatic dispatch(input string tag, input logic [31:0] wr, input logic [31:0] rd,
                            input logic [2:0] exp_id);
        offer(wr, rd);
        #1;
        chk({tag, "_rdy"}, 32'(disp_ready_o), 32'd1);
        chk({tag, "_id"}, 32'(disp_id_o), 32'(exp_id));
        tick();
        idle();
    endtask

    initial begin
        sync_rst_i = 1'b1;
        idle();
        tick();
        tick();
        sync_rst_i = 1'b0;
        #1;
        chk("rst_ready", 32'(disp_ready_o), 32'd1);
        chk("rst_id", 32'(disp_id_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_pwr", pend_wr_o, 32'h0);
        chk("rst_prd", pend_rd_o, 32'h0);

        // 1: first dispatch visible next cycle
        dispatch("t1", 32'h0000_0010, 32'h0000_0006, 3'd0);
        #1;
        chk("t1_pwr", pend_wr_o, 32'h10);
        chk("t1_prd", pend_rd_o, 32'h6);
        chk("t1_busy", 32'(busy_o), 32'd1);

        // 2: RAW stall, released one cycle after wr_clr
        offer(32'h0, 32'h10);
        #1;
        chk("t2_raw_stall", 32'(disp_ready_o), 32'd0);
        wr_clr_valid_i = 1'b1;
        wr_clr_id_i    = 3'd0;
        wr_clr_mask_i  = 32'h10;
        #1;
        chk("t2_no_bypass", 32'(disp_ready_o), 32'd0);
        tick();
        wr_clr_valid_i = 1'b0;
        #1;
        chk("t2_rel_ready", 32'(disp_ready_o), 32'd1);
        chk("t2_rel_id", 32'(disp_id_o), 32'd1);
        tick();
        idle();
        #1;
        chk("t2_pwr", pend_wr_o, 32'h0);
        chk("t2_prd", pend_rd_o, 32'h16);

        // 3: WAR stall released by rd_clr
        do_reset();
        dispatch("t3a", 32'h0, 32'h300, 3'd0);
        offer(32'h100, 32'h0);
        #1;
        chk("t3_war_stall", 32'(disp_ready_o), 32'd0);
        rd_clr_valid_i = 1'b1;
        rd_clr_id_i    = 3'd0;
        rd_clr_mask_i  = 32'h100;
        #1;
        chk("t3_no_bypass", 32'(disp_ready_o), 32'd0);
        tick();
        rd_clr_valid_i = 1'b0;
        #1;
        chk("t3_rel_ready", 32'(disp_ready_o), 32'd1);
        chk("t3_rel_id", 32'(disp_id_o), 32'd1);
        tick();
        idle();
        #1;
        chk("t3_pwr", pend_wr_o, 32'h100);
        chk("t3_prd", pend_rd_o, 32'h200);

        // WAW stall and self read/write of the same vreg
        offer(32'h100, 32'h0);
        #1;
        chk("waw_stall", 32'(disp_ready_o), 32'd0);
        do_reset();
        dispatch("self_rw", 32'h4, 32'h4, 3'd0);
        offer(32'h0, 32'h4);
        #1;
        chk("raw_after_self", 32'(disp_ready_o), 32'd0);
        idle();

        // 4: fill with zero-mask instructions, then free slot 3
        do_reset();
        for (int i = 0; i < 8; i++) begin
            dispatch($sformatf("t4_fill%0d", i), 32'h0, 32'h0, 3'(i));
        end
        offer(32'h0, 32'h0);
        #1;
        chk("t4_full_ready", 32'(disp_ready_o), 32'd0);
        chk("t4_full_id", 32'(disp_id_o), 32'd0);
        chk("t4_full_busy", 32'(busy_o), 32'd1);
        done_valid_i = 1'b1;
        done_id_i    = 3'd3;
        #1;
        chk("t4_done_no_bypass", 32'(disp_ready_o), 32'd0);
        tick();
        done_valid_i = 1'b0;
        #1;
        chk("t4_reuse_ready", 32'(disp_ready_o), 32'd1);
        chk("t4_reuse_id", 32'(disp_id_o), 32'd3);
        tick();
        #1;
        chk("t4_full_again", 32'(disp_ready_o), 32'd0);
        idle();

        // 5: simultaneous clears and done on one id; clear to invalid id ignored
        do_reset();
        dispatch("t5a", 32'h0, 32'h0, 3'd0);
        dispatch("t5b", 32'h0, 32'h0, 3'd1);
        dispatch("t5c", 32'h1, 32'h2, 3'd2);
        #1;
        chk("t5_pwr_pre", pend_wr_o, 32'h1);
        chk("t5_prd_pre", pend_rd_o, 32'h2);
        wr_clr_valid_i = 1'b1;
        wr_clr_id_i    = 3'd2;
        wr_clr_mask_i  = 32'h1;
        rd_clr_valid_i = 1'b1;
        rd_clr_id_i    = 3'd2;
        rd_clr_mask_i  = 32'h2;
        done_valid_i   = 1'b1;
        done_id_i      = 3'd2;
        tick();
        idle();
        #1;
        chk("t5_pwr_post", pend_wr_o, 32'h0);
        chk("t5_prd_post", pend_rd_o, 32'h0);
        chk("t5_busy", 32'(busy_o), 32'd1);
        chk("t5_free_id", 32'(disp_id_o), 32'd2);
        dispatch("t5d", 32'hF0, 32'h0F, 3'd2);
        wr_clr_valid_i = 1'b1;
        wr_clr_id_i    = 3'd5;
        wr_clr_mask_i  = 32'hFFFF_FFFF;
        tick();
        idle();
        #1;
        chk("t5_inv_pwr", pend_wr_o, 32'hF0);
        chk("t5_inv_prd", pend_rd_o, 32'h0F);
        chk("t5_inv_id", 32'(disp_id_o), 32'd3);

        // 6: reset while four entries valid and a dispatch fires
        do_reset();
        for (int i = 0; i < 4; i++) begin
            dispatch($sformatf("t6_fill%0d", i), 32'(1) << i, 32'h0, 3'(i));
        end
        offer(32'h100, 32'h0);
        #1;
        chk("t6_fire_ready", 32'(disp_ready_o), 32'd1);
        chk("t6_fire_id", 32'(disp_id_o), 32'd4);
        sync_rst_i = 1'b1;
        done_valid_i = 1'b1;
        done_id_i    = 3'd1;
        tick();
        sync_rst_i = 1'b0;
        idle();
        #1;
        chk("t6_busy", 32'(busy_o), 32'd0);
        chk("t6_pwr", pend_wr_o, 32'h0);
        chk("t6_prd", pend_rd_o, 32'h0);
        chk("t6_ready", 32'(disp_ready_o), 32'd1);
        chk("t6_id", 32'(disp_id_o), 32'd0);
        done_valid_i   = 1'b1;
        done_id_i      = 3'd0;
        rd_clr_valid_i = 1'b1;
        rd_clr_id_i    = 3'd1;
        rd_clr_mask_i  = 32'hFFFF_FFFF;
        tick();
        idle();
        #1;
        chk("t6_stale_busy", 32'(busy_o), 32'd0);
        chk("t6_stale_id", 32'(disp_id_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
